// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_REQ masters.
// One access is outstanding at a time. A refresh pulse precedes an access whenever
// the owner changes or the granted master asks for one.
module sdram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    input  logic [NUM_REQ-1:0]          req_refresh,
    output logic [NUM_REQ-1:0]          req_finished,
    output logic [DATA_W-1:0]           req_readdata,
    output logic                        sdram_read,
    output logic                        sdram_write,
    output logic [ADDR_W-1:0]           sdram_addr,
    output logic [DATA_W-1:0]           sdram_writedata,
    output logic                        sdram_refresh,
    input  logic [DATA_W-1:0]           sdram_readdata,
    input  logic                        sdram_finished
);

    localparam int unsigned NR = NUM_REQ;
    localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REFR,
        BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      prev_owner;
    logic               prev_valid;
    logic               cmd_read;
    logic               cmd_write;

    logic [NUM_REQ-1:0] pending;
    logic [GW-1:0]      sel;
    logic               sel_found;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_read;
    logic               sel_write;
    logic               sel_refresh;
    logic               need_refresh;

    // A master whose completion pulse is up still holds its old request; mask it.
    assign pending = (req_read | req_write) & ~req_finished;

    // Pick the first pending master after last_grant, wrapping cyclically.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = 32'(last_grant) + i;
            if (idx >= NR) begin
                idx = idx - NR;
            end
            for (int unsigned k = 0; k < NR; k++) begin
                if (!sel_found && idx == k && pending[k]) begin
                    sel       = GW'(k);
                    sel_found = 1'b1;
                end
            end
        end
    end

    // Route the selected master's request fields.
    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_read    = 1'b0;
        sel_write   = 1'b0;
        sel_refresh = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (sel == GW'(k)) begin
                sel_addr    = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata   = req_writedata[k*DATA_W +: DATA_W];
                sel_read    = req_read[k];
                sel_write   = req_write[k];
                sel_refresh = req_refresh[k];
            end
        end
    end

    assign need_refresh = !prev_valid || (sel != prev_owner) || sel_refresh;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> (REFR) -> BUSY -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = need_refresh ? REFR : BUSY;
                end
            end
            REFR: state_next = BUSY;
            BUSY: begin
                if (sdram_finished) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command and refresh outputs decoded from state and the latched command.
    always_comb begin
        sdram_read    = 1'b0;
        sdram_write   = 1'b0;
        sdram_refresh = 1'b0;
        case (state)
            REFR: sdram_refresh = 1'b1;
            BUSY: begin
                sdram_read  = cmd_read;
                sdram_write = cmd_write;
            end
            default: ;
        endcase
    end

    // Latch the granted request in IDLE; on completion pulse the owner and update history.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_grant      <= GW'(NR - 1);
            prev_owner      <= '0;
            prev_valid      <= 1'b0;
            grant           <= '0;
            cmd_read        <= 1'b0;
            cmd_write       <= 1'b0;
            sdram_addr      <= '0;
            sdram_writedata <= '0;
            req_finished    <= '0;
            req_readdata    <= '0;
        end else begin
            req_finished <= '0;
            if (state == IDLE && sel_found) begin
                grant           <= sel;
                cmd_write       <= sel_write;
                cmd_read        <= sel_read & ~sel_write;
                sdram_addr      <= sel_addr;
                sdram_writedata <= sel_wdata;
            end
            if (state == BUSY && sdram_finished) begin
                req_finished[grant] <= 1'b1;
                if (cmd_read) begin
                    req_readdata <= sdram_readdata;
                end
                last_grant <= grant;
                prev_owner <= grant;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule
